// File: rtl/inv_shift_row_byte_sub.sv
// AES decrypt inverse ShiftRows + inverse SubBytes, applied in place on the shared statemt memory.
// Optional build macro AES_INVSB_RANGE_CHECK_EN adds a sticky range_err flag for nonzero upper read bits.
module inv_shift_row_byte_sub (
`ifdef AES_INVSB_RANGE_CHECK_EN
    output logic        range_err,
`endif
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [4:0]  statemt_address0,
    output logic        statemt_ce0,
    output logic        statemt_we0,
    output logic [31:0] statemt_d0,
    input  logic [31:0] statemt_q0,
    output logic [4:0]  statemt_address1,
    output logic        statemt_ce1,
    output logic        statemt_we1,
    output logic [31:0] statemt_d1,
    input  logic [31:0] statemt_q1,
    output logic [7:0]  invSbox_address0,
    output logic        invSbox_ce0,
    input  logic [7:0]  invSbox_q0,
    output logic [7:0]  invSbox_address1,
    output logic        invSbox_ce1,
    input  logic [7:0]  invSbox_q1
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_LK, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  k, k_nxt;
    logic [3:0]  km1;
    logic [7:0]  state_buf [16];
    logic        unused_bits;

    // Source byte for output o: row r = o[1:0] rotated right by r, so column becomes (c - r) mod 4.
    function automatic logic [3:0] src_idx(input logic [3:0] o);
        logic [1:0] col;
        col = o[3:2] - o[1:0];
        return {col, o[1:0]};
    endfunction

    assign km1         = k - 4'd1;
    assign ap_idle     = (state == S_IDLE) && !ap_start;
    assign unused_bits = ^{statemt_q0[31:8], statemt_q1[31:8], km1[3]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        k_nxt            = k;
        ap_done          = 1'b0;
        ap_ready         = 1'b0;
        statemt_address0 = 5'd0;
        statemt_address1 = 5'd0;
        statemt_ce0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_d0       = 32'd0;
        statemt_d1       = 32'd0;
        invSbox_address0 = 8'd0;
        invSbox_address1 = 8'd0;
        invSbox_ce0      = 1'b0;
        invSbox_ce1      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = S_RD;
                    k_nxt     = 4'd0;
                end
            end
            S_RD: begin
                if (!k[3]) begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_address0 = {1'b0, k[2:0], 1'b0};
                    statemt_address1 = {1'b0, k[2:0], 1'b1};
                end
                if (k == 4'd8) begin
                    state_nxt = S_LK;
                    k_nxt     = 4'd0;
                end else begin
                    k_nxt = k + 4'd1;
                end
            end
            S_LK: begin
                // ROM lookup for pair k overlaps the write-back of pair k-1.
                if (!k[3]) begin
                    invSbox_ce0      = 1'b1;
                    invSbox_ce1      = 1'b1;
                    invSbox_address0 = state_buf[src_idx({k[2:0], 1'b0})];
                    invSbox_address1 = state_buf[src_idx({k[2:0], 1'b1})];
                end
                if (k != 4'd0) begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_we0      = 1'b1;
                    statemt_we1      = 1'b1;
                    statemt_address0 = {1'b0, km1[2:0], 1'b0};
                    statemt_address1 = {1'b0, km1[2:0], 1'b1};
                    statemt_d0       = {24'd0, invSbox_q0};
                    statemt_d1       = {24'd0, invSbox_q1};
                end
                if (k == 4'd8) begin
                    state_nxt = S_DONE;
                    k_nxt     = 4'd0;
                end else begin
                    k_nxt = k + 4'd1;
                end
            end
            S_DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = S_IDLE;
                k_nxt     = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                k_nxt     = 4'd0;
            end
        endcase
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge ap_clk) begin
        if (state == S_RD && k != 4'd0) begin
            state_buf[{km1[2:0], 1'b0}] <= statemt_q0[7:0];
            state_buf[{km1[2:0], 1'b1}] <= statemt_q1[7:0];
        end
    end

`ifdef AES_INVSB_RANGE_CHECK_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            range_err <= 1'b0;
        end else if (state == S_IDLE && ap_start) begin
            range_err <= 1'b0;
        end else if (state == S_RD && k != 4'd0 &&
                     ((|statemt_q0[31:8]) || (|statemt_q1[31:8]))) begin
            range_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inv_shift_row_byte_sub.sv
// Self-checking bench for inv_shift_row_byte_sub: models statemt and the inverse S-box ROM,
// compares in-place results against a row-rotation/S-box reference and checks handshake timing.
module tb_inv_shift_row_byte_sub;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  statemt_address0, statemt_address1;
    logic        statemt_ce0, statemt_ce1, statemt_we0, statemt_we1;
    logic [31:0] statemt_d0, statemt_d1, statemt_q0, statemt_q1;
    logic [7:0]  invSbox_address0, invSbox_address1;
    logic        invSbox_ce0, invSbox_ce1;
    logic [7:0]  invSbox_q0, invSbox_q1;
`ifdef AES_INVSB_RANGE_CHECK_EN
    logic        range_err;
`endif

    logic [31:0] mem   [32];
    logic [31:0] stage [32];
    logic        load_req = 1'b0;
    logic [7:0]  inv_sb    [256];
    logic [7:0]  model_in  [16];
    logic [7:0]  model_out [16];
    int          vectors = 0;
    int          miscompares = 0;
    int          hi_addr_hits = 0;

    inv_shift_row_byte_sub dut (
`ifdef AES_INVSB_RANGE_CHECK_EN
        .range_err        (range_err),
`endif
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .statemt_address0 (statemt_address0),
        .statemt_ce0      (statemt_ce0),
        .statemt_we0      (statemt_we0),
        .statemt_d0       (statemt_d0),
        .statemt_q0       (statemt_q0),
        .statemt_address1 (statemt_address1),
        .statemt_ce1      (statemt_ce1),
        .statemt_we1      (statemt_we1),
        .statemt_d1       (statemt_d1),
        .statemt_q1       (statemt_q1),
        .invSbox_address0 (invSbox_address0),
        .invSbox_ce0      (invSbox_ce0),
        .invSbox_q0       (invSbox_q0),
        .invSbox_address1 (invSbox_address1),
        .invSbox_ce1      (invSbox_ce1),
        .invSbox_q1       (invSbox_q1)
    );

    always #5 ap_clk = ~ap_clk;

    // Dual-port read-first state memory and ROM, both with one-cycle read latency.
    always @(posedge ap_clk) begin
        if (load_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= stage[i];
        end else begin
            if (statemt_ce0) begin
                if (statemt_we0) mem[statemt_address0] <= statemt_d0;
                statemt_q0 <= mem[statemt_address0];
            end
            if (statemt_ce1) begin
                if (statemt_we1) mem[statemt_address1] <= statemt_d1;
                statemt_q1 <= mem[statemt_address1];
            end
        end
        if (invSbox_ce0) invSbox_q0 <= inv_sb[invSbox_address0];
        if (invSbox_ce1) invSbox_q1 <= inv_sb[invSbox_address1];
    end

    always @(negedge ap_clk) begin
        if ((statemt_ce0 && statemt_address0[4]) || (statemt_ce1 && statemt_address1[4]))
            hi_addr_hits++;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Inverse S-box derived from the GF(2^8) inverse plus the forward affine map.
    task automatic buildInvSbox();
        logic [7:0] inv_x, b, fwd;
        for (int x = 0; x < 256; x++) begin
            inv_x = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
            b   = inv_x;
            fwd = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            inv_sb[fwd] = 8'(x);
        end
    endtask

    // Reference: view bytes as a 4x4 column-major matrix, rotate row r right by r, then substitute.
    function automatic void runModel();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                model_out[r + 4 * c] = inv_sb[model_in[r + 4 * ((c - r + 4) % 4)]];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic loadBlock();
        load_req = 1'b1;
        @(negedge ap_clk);
        load_req = 1'b0;
        for (int i = 0; i < 16; i++) model_in[i] = stage[i][7:0];
        runModel();
    endtask

    task automatic checkMemory(input string tag);
        for (int o = 0; o < 16; o++)
            checkOutput($sformatf("%s_mem%0d", tag, o), mem[o], {24'd0, model_out[o]});
        for (int i = 16; i < 32; i++)
            checkOutput($sformatf("%s_hi%0d", tag, i), mem[i], stage[i]);
    endtask

    // Starts one block at the current negedge (cycle 0) and watches a fixed 30-cycle window.
    task automatic applyStimulus(input int pulse_at, output int done_cycle, output int ready_cycle,
                                 output int done_count, output int first_wr, output int last_wr,
                                 output logic [4:0] first_wr_addr);
        done_cycle = -1; ready_cycle = -1; done_count = 0;
        first_wr = -1; last_wr = -1; first_wr_addr = 5'd0;
        ap_start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge ap_clk);
            ap_start = (n == pulse_at);
            #1;
            if (ap_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = n;
            end
            if (ap_ready && ready_cycle < 0) ready_cycle = n;
            if (statemt_ce0 && statemt_we0) begin
                if (first_wr < 0) begin
                    first_wr = n;
                    first_wr_addr = statemt_address0;
                end
                last_wr = n;
            end
        end
    endtask

    int         dc, rc, cnt, fw, lw, idle_hits, late_dones;
    logic [4:0] fwa;
    int         done_q [$];

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        buildInvSbox();
        for (int i = 16; i < 32; i++) stage[i] = 32'hA5A5_0000 | i;
        #2;
        checkOutput("rst_done",  32'(ap_done), 0);
        checkOutput("rst_ready", 32'(ap_ready), 0);
        checkOutput("rst_idle",  32'(ap_idle), 1);
        checkOutput("rst_en", 32'({statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, invSbox_ce0, invSbox_ce1}), 0);
        checkOutput("rst_addr", 32'({statemt_address0, statemt_address1, invSbox_address0, invSbox_address1}), 0);
        checkOutput("rst_d", statemt_d0 | statemt_d1, 0);
`ifdef AES_INVSB_RANGE_CHECK_EN
        checkOutput("rst_range_err", 32'(range_err), 0);
`endif
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Identity preload: known FIPS-197 inverse S-box values and handshake timing.
        for (int i = 0; i < 16; i++) stage[i] = 32'(i);
        loadBlock();
        applyStimulus(0, dc, rc, cnt, fw, lw, fwa);
        checkOutput("t1_done_cycle", 32'(dc), 19);
        checkOutput("t1_ready_cycle", 32'(rc), 19);
        checkOutput("t1_done_count", 32'(cnt), 1);
        checkOutput("t1_first_wr", 32'(fw), 11);
        checkOutput("t1_first_wr_addr", 32'(fwa), 0);
        checkOutput("t1_last_wr", 32'(lw), 18);
        checkOutput("t1_b0",  mem[0],  32'h52);
        checkOutput("t1_b1",  mem[1],  32'hF3);
        checkOutput("t1_b2",  mem[2],  32'hA3);
        checkOutput("t1_b5",  mem[5],  32'h09);
        checkOutput("t1_b10", mem[10], 32'h6A);
        checkOutput("t1_b15", mem[15], 32'hD5);
        checkMemory("t1");

        for (int i = 0; i < 16; i++) stage[i] = 32'h63;
        loadBlock();
        applyStimulus(0, dc, rc, cnt, fw, lw, fwa);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("t2_zero%0d", i), mem[i], 0);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) stage[i] = {24'd0, 8'($urandom)};
            loadBlock();
            applyStimulus(0, dc, rc, cnt, fw, lw, fwa);
            checkOutput($sformatf("t3_%0d_done_cycle", t), 32'(dc), 19);
            checkMemory($sformatf("t3_%0d", t));
        end

        // Start held high: back-to-back blocks, each reading the previous block's output.
        for (int i = 0; i < 16; i++) stage[i] = {24'd0, 8'($urandom)};
        loadBlock();
        idle_hits = 0; late_dones = 0; done_q.delete();
        ap_start = 1'b1;
        #1;
        if (ap_idle) idle_hits++;
        for (int n = 1; n <= 64; n++) begin
            @(negedge ap_clk);
            if (n == 45) ap_start = 1'b0;
            #1;
            if (n <= 44) begin
                if (ap_idle) idle_hits++;
                if (ap_done) done_q.push_back(n);
            end else if (ap_done) begin
                late_dones++;
            end
        end
        checkOutput("t4_done_count", 32'(done_q.size()), 2);
        checkOutput("t4_done0", 32'((done_q.size() > 0) ? done_q[0] : -1), 19);
        checkOutput("t4_done1", 32'((done_q.size() > 1) ? done_q[1] : -1), 39);
        checkOutput("t4_idle_hits", 32'(idle_hits), 0);
        checkOutput("t4_third_done", 32'(late_dones), 1);
        for (int p = 0; p < 3; p++) begin
            if (p > 0) for (int i = 0; i < 16; i++) model_in[i] = model_out[i];
            runModel();
        end
        checkMemory("t4");

        // Reset in cycle 12: only bytes 0/1 (written at the end of cycle 11) are updated.
        for (int i = 0; i < 16; i++) stage[i] = {24'd0, 8'($urandom)};
        loadBlock();
        ap_start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
        end
        ap_rst_n = 1'b0;
        #1;
        checkOutput("t5_en_drop", 32'({statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, invSbox_ce0, invSbox_ce1}), 0);
        checkOutput("t5_idle", 32'(ap_idle), 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        checkOutput("t5_part0", mem[0], {24'd0, model_out[0]});
        checkOutput("t5_part1", mem[1], {24'd0, model_out[1]});
        checkOutput("t5_part2", mem[2], {24'd0, model_in[2]});
        checkOutput("t5_part15", mem[15], {24'd0, model_in[15]});
        model_in[0] = model_out[0];
        model_in[1] = model_out[1];
        runModel();
        applyStimulus(0, dc, rc, cnt, fw, lw, fwa);
        checkOutput("t5_done_cycle", 32'(dc), 19);
        checkMemory("t5");

        for (int i = 0; i < 16; i++) stage[i] = {24'd0, 8'($urandom)};
        loadBlock();
        applyStimulus(13, dc, rc, cnt, fw, lw, fwa);
        checkOutput("t6_done_cycle", 32'(dc), 19);
        checkOutput("t6_done_count", 32'(cnt), 1);
        checkMemory("t6");

        // Nonzero upper bits on byte 7 are ignored by the substitution.
        for (int i = 0; i < 16; i++) stage[i] = 32'(i);
        stage[7] = 32'h0000_0107;
        loadBlock();
        applyStimulus(0, dc, rc, cnt, fw, lw, fwa);
        checkMemory("t7");
`ifdef AES_INVSB_RANGE_CHECK_EN
        checkOutput("t7_range_err_set", 32'(range_err), 1);
        stage[7] = 32'h0000_0007;
        loadBlock();
        applyStimulus(0, dc, rc, cnt, fw, lw, fwa);
        checkOutput("t7_range_err_clear", 32'(range_err), 0);
        checkMemory("t7b");
`endif

        checkOutput("hi_addr_hits", 32'(hi_addr_hits), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
